// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared SISC opcode, addressing-mode and instruction-field definitions
//
// Purpose: constants shared by the SISC control FSM and datapath blocks.
//   - opcode encodings (IR[31:28])
//   - addressing-mode encoding for immediate operands (IR[27:24])
//   - bit positions of every instruction field in the 32-bit IR
// Ports: none (package).

package sisc_pkg;

  // Opcode encodings
  localparam logic [3:0] NOOP   = 4'd0;
  localparam logic [3:0] LOD    = 4'd1;
  localparam logic [3:0] STR    = 4'd2;
  localparam logic [3:0] BRA    = 4'd4;
  localparam logic [3:0] BRR    = 4'd5;
  localparam logic [3:0] BNE    = 4'd6;
  localparam logic [3:0] ALU_OP = 4'd8;
  localparam logic [3:0] HLT    = 4'd15;

  // Addressing mode: operand is the immediate field
  localparam logic [3:0] am_imm = 4'd8;

  // Instruction field bit positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;
  localparam int MM_MSB     = 27;
  localparam int MM_LSB     = 24;
  localparam int RD_MSB     = 23;
  localparam int RD_LSB     = 20;
  localparam int RS_MSB     = 19;
  localparam int RS_LSB     = 16;
  localparam int RT_MSB     = 15;
  localparam int RT_LSB     = 12;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  localparam int INSTR_W    = 32;
  localparam int IMM_W      = IMM_MSB - IMM_LSB + 1;

  // The all-zero instruction word decodes as NOOP
  localparam logic [INSTR_W-1:0] NOOP_INSTR = '0;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-PC selection for the SISC fetch unit
//
// Purpose: computes the value the PC takes when the control FSM asserts pc_write.
// Ports:
//   pc       in  AW  current program counter
//   imm      in  16  immediate field of the current IR
//   pc_sel   in  1   0: sequential (PC+1), 1: branch target
//   br_sel   in  1   1: absolute target (imm), 0: relative target (PC + sext(imm))
//   next_pc  out AW  selected next PC, modulo 2^AW

module pc_next
  import sisc_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic [AW-1:0]    pc,
  input  logic [IMM_W-1:0] imm,
  input  logic             pc_sel,
  input  logic             br_sel,
  output logic [AW-1:0]    next_pc
);

  // Relative targets use a sign-extended offset; absolute targets are
  // zero-extended. When the PC is no wider than the immediate both reduce
  // to the low AW bits of imm.
  logic [AW-1:0] imm_sext;
  logic [AW-1:0] imm_zext;

  generate
    if (AW > IMM_W) begin : g_wide
      assign imm_sext = {{(AW-IMM_W){imm[IMM_W-1]}}, imm};
      assign imm_zext = {{(AW-IMM_W){1'b0}}, imm};
    end else begin : g_narrow
      assign imm_sext = imm[AW-1:0];
      assign imm_zext = imm[AW-1:0];
    end
  endgenerate

  // Adders deliberately drop the carry: PC wrap-around is silent.
  always_comb begin
    next_pc = pc + AW'(1);
    if (pc_sel) begin
      if (br_sel) begin
        next_pc = imm_zext;
      end else begin
        next_pc = pc + imm_sext;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - SISC program counter, instruction register and instruction fetch
//
// Purpose: datapath-side responder to the SISC control FSM. Owns PC and IR,
// fetches 32-bit instructions over a req/ack handshake with a bounded wait,
// and exposes the decoded IR fields.
// Ports:
//   clk        in  1   system clock
//   rst_f      in  1   asynchronous active-low reset
//   pc_rst     in  1   synchronous PC/IR clear (fetch_err is kept)
//   pc_write   in  1   load PC with the next-PC value
//   pc_sel     in  1   0: PC+1, 1: branch target
//   br_sel     in  1   1: absolute target, 0: PC-relative target
//   ir_load    in  1   start a fetch at the current PC
//   im_ack     in  1   instruction memory data valid
//   im_rdata   in  32  instruction memory read data
//   im_req     out 1   fetch request
//   im_addr    out AW  fetch address, held for the whole request
//   opcode     out 4   IR[31:28]
//   mm         out 4   IR[27:24]
//   rd         out 4   IR[23:20]
//   rs         out 4   IR[19:16]
//   rt         out 4   IR[15:12]
//   imm        out 16  IR[15:0]
//   pc_out     out AW  current PC
//   if_busy    out 1   fetch in flight
//   ir_valid   out 1   IR holds a completed fetch
//   fetch_err  out 1   sticky fetch-timeout flag

module fetch_unit
  import sisc_pkg::*;
#(
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               pc_rst,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               ir_load,
  input  logic               im_ack,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic               im_req,
  output logic [AW-1:0]      im_addr,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [3:0]         rt,
  output logic [IMM_W-1:0]   imm,
  output logic [AW-1:0]      pc_out,
  output logic               if_busy,
  output logic               ir_valid,
  output logic               fetch_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  // Counter value during the last permitted REQ cycle; an ack in that cycle
  // still completes the fetch normally.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [0:0]         state;
  logic [AW-1:0]      pc;
  logic [INSTR_W-1:0] ir;
  logic [AW-1:0]      addr;
  logic               valid;
  logic               err;
  logic [7:0]         wait_cnt;
  logic [AW-1:0]      next_pc;

  pc_next #(
    .AW(AW)
  ) u_pc_next (
    .pc      (pc),
    .imm     (ir[IMM_MSB:IMM_LSB]),
    .pc_sel  (pc_sel),
    .br_sel  (br_sel),
    .next_pc (next_pc)
  );

  // PC register. Updates independently of the fetch state; the fetch path
  // below latches the pre-update PC when both strobes coincide.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc <= RESET_PC;
    end else if (pc_rst) begin
      pc <= RESET_PC;
    end else if (pc_write) begin
      pc <= next_pc;
    end
  end

  // Fetch sequencer and IR.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state    <= S_IDLE;
      ir       <= NOOP_INSTR;
      addr     <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= '0;
    end else if (pc_rst) begin
      // Abort any fetch in flight; the error flag survives.
      state    <= S_IDLE;
      ir       <= NOOP_INSTR;
      addr     <= '0;
      valid    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ir_load) begin
            state    <= S_REQ;
            addr     <= pc;
            valid    <= 1'b0;
            wait_cnt <= '0;
          end
        end
        S_REQ: begin
          if (im_ack) begin
            state <= S_IDLE;
            ir    <= im_rdata;
            valid <= 1'b1;
          end else if (wait_cnt == TMO_LAST) begin
            // Hand the FSM a NOOP so it can proceed; fetch_err records why.
            state <= S_IDLE;
            ir    <= NOOP_INSTR;
            valid <= 1'b1;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign im_req    = (state == S_REQ);
  assign if_busy   = (state == S_REQ);
  assign im_addr   = addr;
  assign pc_out    = pc;
  assign ir_valid  = valid;
  assign fetch_err = err;

  assign opcode = ir[OPCODE_MSB:OPCODE_LSB];
  assign mm     = ir[MM_MSB:MM_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign rs     = ir[RS_MSB:RS_LSB];
  assign rt     = ir[RT_MSB:RT_LSB];
  assign imm    = ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit

module tb_fetch_unit;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic        pc_rst = 1'b0;
  logic        pc_write = 1'b0;
  logic        pc_sel = 1'b0;
  logic        br_sel = 1'b0;
  logic        ir_load = 1'b0;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = 32'h0;
  logic        im_req;
  logic [15:0] im_addr;
  logic [3:0]  opcode, mm, rd, rs, rt;
  logic [15:0] imm;
  logic [15:0] pc_out;
  logic        if_busy, ir_valid, fetch_err;

  fetch_unit #(
    .AW(16), .RESET_PC(16'h0000), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write),
    .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load), .im_ack(im_ack),
    .im_rdata(im_rdata), .im_req(im_req), .im_addr(im_addr),
    .opcode(opcode), .mm(mm), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .pc_out(pc_out), .if_busy(if_busy), .ir_valid(ir_valid),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an outstanding fetch is an address plus the number of
  // request cycles already spent on it; memory results land in a 32-bit IR.
  logic [15:0] m_pc, m_addr;
  logic [31:0] m_ir;
  bit          m_valid, m_err, m_fetching;
  int          m_spent;

  always @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      m_pc = 16'h0; m_addr = 16'h0; m_ir = 32'h0;
      m_valid = 0; m_err = 0; m_fetching = 0; m_spent = 0;
    end else if (pc_rst) begin
      m_pc = 16'h0; m_addr = 16'h0; m_ir = 32'h0;
      m_valid = 0; m_fetching = 0; m_spent = 0;
    end else begin
      logic [15:0] pc_before;
      pc_before = m_pc;
      if (pc_write) begin
        if (!pc_sel)     m_pc = m_pc + 16'd1;
        else if (br_sel) m_pc = m_ir[15:0];
        else             m_pc = m_pc + m_ir[15:0];
      end
      if (!m_fetching) begin
        if (ir_load) begin
          m_fetching = 1; m_addr = pc_before; m_valid = 0; m_spent = 0;
        end
      end else begin
        m_spent++;
        if (im_ack) begin
          m_ir = im_rdata; m_valid = 1; m_fetching = 0;
        end else if (m_spent >= TMO) begin
          m_ir = 32'h0; m_valid = 1; m_err = 1; m_fetching = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_f) begin
      chk("m_im_req",    32'(im_req),    32'(m_fetching));
      chk("m_if_busy",   32'(if_busy),   32'(m_fetching));
      chk("m_im_addr",   32'(im_addr),   32'(m_addr));
      chk("m_pc",        32'(pc_out),    32'(m_pc));
      chk("m_ir",        {opcode, mm, rd, rs, imm}, m_ir);
      chk("m_rt",        32'(rt),        32'(m_ir[15:12]));
      chk("m_ir_valid",  32'(ir_valid),  32'(m_valid));
      chk("m_fetch_err", 32'(fetch_err), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic fetch(input logic [31:0] data, input int waits);
    ir_load = 1; step(); ir_load = 0;
    repeat (waits) step();
    im_ack = 1; im_rdata = data; step();
    im_ack = 0; im_rdata = 32'h0;
  endtask

  task automatic pc_inc(input int n);
    pc_write = 1; pc_sel = 0;
    repeat (n) step();
    pc_write = 0;
  endtask

  task automatic pc_branch(input logic absolute);
    pc_write = 1; pc_sel = 1; br_sel = absolute; step();
    pc_write = 0; pc_sel = 0; br_sel = 0;
  endtask

  initial begin
    // Reset
    #1 rst_f = 0;
    #1;
    chk("rst_im_req", 32'(im_req), 32'h0);
    chk("rst_pc", 32'(pc_out), 32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("rst_fetch_err", 32'(fetch_err), 32'h0);
    @(negedge clk); #2; rst_f = 1; chk_en = 1;
    step();

    // Fetch at PC=5 with three wait cycles
    pc_inc(5);
    chk("pc_5", 32'(pc_out), 32'h5);
    ir_load = 1; step(); ir_load = 0;
    chk("req_addr_0", 32'(im_addr), 32'h5);
    chk("req_busy", 32'(if_busy), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("req_addr_w", 32'(im_addr), 32'h5);
      chk("req_held", 32'(im_req), 32'h1);
    end
    im_ack = 1; im_rdata = 32'h81230000; step(); im_ack = 0; im_rdata = 0;
    chk("f_opcode", 32'(opcode), 32'h8);
    chk("f_mm", 32'(mm), 32'h1);
    chk("f_rd", 32'(rd), 32'h2);
    chk("f_rs", 32'(rs), 32'h3);
    chk("f_valid", 32'(ir_valid), 32'h1);
    chk("f_req_low", 32'(im_req), 32'h0);

    // Branches
    fetch(32'h40000010, 0);
    pc_branch(1);
    chk("br_abs_10", 32'(pc_out), 32'h0010);
    fetch(32'h5000FFFE, 1);
    pc_branch(0);
    chk("br_rel_neg", 32'(pc_out), 32'h000E);
    fetch(32'h40001234, 2);
    pc_branch(1);
    chk("br_abs_1234", 32'(pc_out), 32'h1234);
    fetch(32'h4000FFFF, 0);
    pc_branch(1);
    pc_inc(1);
    chk("pc_wrap", 32'(pc_out), 32'h0000);

    // ir_load together with pc_write at PC=7, then ir_load during REQ
    pc_inc(7);
    ir_load = 1; pc_write = 1; pc_sel = 0; step(); pc_write = 0;
    chk("sim_addr", 32'(im_addr), 32'h7);
    chk("sim_pc", 32'(pc_out), 32'h8);
    pc_write = 1; step(); pc_write = 0;
    step();
    chk("reload_addr", 32'(im_addr), 32'h7);
    chk("reload_pc", 32'(pc_out), 32'h9);
    ir_load = 0; im_ack = 1; im_rdata = 32'h10000042; step(); im_ack = 0;
    chk("reload_done", 32'(im_req), 32'h0);
    step();
    chk("no_queue", 32'(im_req), 32'h0);
    chk("reload_imm", 32'(imm), 32'h0042);

    // Ack in the last permitted request cycle
    ir_load = 1; step(); ir_load = 0;
    repeat (TMO - 1) step();
    chk("edge_req", 32'(im_req), 32'h1);
    im_ack = 1; im_rdata = 32'h2ABCDEF0; step(); im_ack = 0; im_rdata = 0;
    chk("edge_opcode", 32'(opcode), 32'h2);
    chk("edge_imm", 32'(imm), 32'hDEF0);
    chk("edge_no_err", 32'(fetch_err), 32'h0);

    // Timeout
    ir_load = 1; step(); ir_load = 0;
    for (int i = 0; i < TMO - 1; i++) begin
      step();
      chk("tmo_req_held", 32'(im_req), 32'h1);
    end
    step();
    chk("tmo_req_drop", 32'(im_req), 32'h0);
    chk("tmo_ir", {opcode, mm, rd, rs, imm}, 32'h0);
    chk("tmo_err", 32'(fetch_err), 32'h1);
    chk("tmo_valid", 32'(ir_valid), 32'h1);
    im_ack = 1; im_rdata = 32'hFFFFFFFF; step(); im_ack = 0; im_rdata = 0;
    chk("idle_ack_ign", 32'(opcode), 32'h0);
    pc_rst = 1; step(); pc_rst = 0;
    chk("err_sticky", 32'(fetch_err), 32'h1);
    chk("pcrst_pc", 32'(pc_out), 32'h0);

    // pc_rst mid-REQ, overriding pc_write; late ack ignored
    fetch(32'h31110000, 0);
    pc_inc(2);
    ir_load = 1; step(); ir_load = 0;
    step();
    pc_rst = 1; pc_write = 1; step(); pc_rst = 0; pc_write = 0;
    chk("pcrst_req", 32'(im_req), 32'h0);
    chk("pcrst_ir", {opcode, mm, rd, rs, imm}, 32'h0);
    chk("pcrst_pc2", 32'(pc_out), 32'h0);
    im_ack = 1; im_rdata = 32'h8FFF0000; step(); im_ack = 0; im_rdata = 0;
    chk("late_ack_ir", 32'(opcode), 32'h0);
    chk("late_ack_valid", 32'(ir_valid), 32'h0);

    // Asynchronous reset mid-REQ
    fetch(32'hF0000000, 0);
    pc_inc(3);
    ir_load = 1; step(); ir_load = 0;
    #1 rst_f = 0;
    #1;
    chk("arst_req", 32'(im_req), 32'h0);
    chk("arst_pc", 32'(pc_out), 32'h0);
    chk("arst_ir", {opcode, mm, rd, rs, imm}, 32'h0);
    chk("arst_valid", 32'(ir_valid), 32'h0);
    chk("arst_err", 32'(fetch_err), 32'h0);
    @(negedge clk); #2; rst_f = 1;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
